// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect/halt control from
// the back end, and the decode-facing instruction stream.
//
// Decode handshake: a transfer happens on every rising clock edge where
// instr_valid and instr_ready are both high. Once instr_valid is raised,
// instr, instr_pc and instr_valid stay unchanged until that transfer occurs.
// The only exceptions are a redirect or a reset, which discard the
// instruction. instr_valid never depends on instr_ready.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24
);
  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_data_out;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch stage side.
  modport master (
    output imem_address, instr_valid, instr, instr_pc,
    input  imem_data_out, redirect_valid, redirect_pc, halt, instr_ready
  );

  // Memory / control / decode side.
  modport slave (
    input  imem_address, instr_valid, instr, instr_pc,
    output imem_data_out, redirect_valid, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory, and absorbs its one-cycle read latency with a small {pc, instr}
// buffer in front of decode. The issue rule counts the in-flight read as an
// occupied slot, so a returning read always has room in the buffer.
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 24,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_d    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_d [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occ_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake terms: pop from decode, push of the returning read, and the
  // decision to issue a new read this cycle.
  always_comb begin
    pop      = (count_q != '0) & bus.instr_ready;
    push     = pending_q & ~bus.redirect_valid;
    occ_next = OCC_W'(count_q) + OCC_W'(pending_q) - OCC_W'(pop);
    issue    = ~bus.redirect_valid & ~bus.halt & (occ_next < OCC_W'(DEPTH));
  end

  // Next-state logic. A redirect overrides everything else: it flushes the
  // buffer and the in-flight read, then loads the new PC.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      pending_d  = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 1'b1;
      end else begin
        pending_d = 1'b0;
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = pending_pc_q;
        fifo_instr_d[wr_ptr_q] = bus.imem_data_out;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers. The buffer storage is cleared too, so the head outputs
  // read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // All outputs come straight from state.
  assign bus.imem_address = fetch_pc_q;
  assign bus.instr_valid  = (count_q != '0);
  assign bus.instr        = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc     = fifo_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous 256x24 memory model preloaded with
// A00000+i, directed scenarios, and a randomized phase. The reference model is
// a program-order stream. Decode must receive consecutive PCs from the last
// reset or redirect target, each paired with its memory word.
module tb_instruction_fetch;
  localparam int         ADDR_W   = 8;
  localparam int         INSTR_W  = 24;
  localparam int         DEPTH    = 2;
  localparam logic [7:0] RESET_PC = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instruction_fetch #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [INSTR_W-1:0] mem [256];
  always @(posedge clk) bus.imem_data_out <= mem[bus.imem_address];

  // ---------------- scoreboard ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  next_pc;
  logic        obs_valid;
  logic [7:0]  obs_pc;
  logic [23:0] obs_instr;
  logic        hold_prev;
  logic [31:0] prev_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic restart(input logic [7:0] pc);
    exp_q.delete();
    next_pc = pc;
  endtask

  task automatic top_up();
    exp_q.push_back({next_pc, 24'hA00000 + {16'h0, next_pc}});
    next_pc = next_pc + 8'd1;
  endtask

  function automatic logic [7:0] next_exp_pc();
    return (exp_q.size() != 0) ? exp_q[0][31:24] : next_pc;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs at the falling edge, observe outputs there,
  // and settle the model. The rising edge that follows commits the cycle.
  task automatic cycle(input logic rdy, input logic hlt, input logic rv, input logic [7:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    bus.instr_ready    = rdy;
    bus.halt           = hlt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    obs_valid = bus.instr_valid;
    obs_pc    = bus.instr_pc;
    obs_instr = bus.instr;
    if (hold_prev) begin
      check("hold_valid", {31'd0, obs_valid}, 32'd1);
      check("hold_word", {obs_pc, obs_instr}, prev_word);
    end
    if (obs_valid && rdy) begin
      if (exp_q.size() == 0) top_up();
      e = exp_q.pop_front();
      check("pop_word", {obs_pc, obs_instr}, e);
    end
    hold_prev = obs_valid && !rdy && !rv;
    prev_word = {obs_pc, obs_instr};
    if (rv) restart(rpc);
  endtask

  task automatic stream(input int n, input logic chk_valid);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      if (chk_valid) check("no_bubble", {31'd0, obs_valid}, 32'd1);
    end
  endtask

  // Redirect then verify two empty cycles followed by the target's arrival.
  task automatic redirect_to(input logic rdy, input logic [7:0] pc);
    cycle(rdy, 1'b0, 1'b1, pc);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("redir_gap1", {31'd0, obs_valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("redir_gap2", {31'd0, obs_valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("redir_lat", {31'd0, obs_valid}, 32'd1);
    check("redir_pc", {24'd0, obs_pc}, {24'd0, pc});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'hA00000 + 24'(i);
    bus.instr_ready    = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    hold_prev = 1'b0;
    prev_word = '0;
    restart(RESET_PC);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", {8'd0, bus.instr}, 32'd0);
    check("rst_instr_pc", {24'd0, bus.instr_pc}, 32'd0);
    check("rst_addr", {24'd0, bus.imem_address}, {24'd0, RESET_PC});

    // Release reset: valid rises on the third cycle.
    rst_n = 1'b1;
    check("lat_c1", {31'd0, bus.instr_valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("lat_c2", {31'd0, obs_valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("lat_c3", {31'd0, obs_valid}, 32'd1);
    stream(8, 1'b1);

    // PC wrap FC..FF,00.. with no bubbles.
    redirect_to(1'b1, 8'hFC);
    stream(6, 1'b1);

    // Stall for 5 cycles: head holds, fetch stops DEPTH ahead of the head.
    for (int s = 0; s < 5; s++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      if (s >= 2) check("stall_addr", {24'd0, bus.imem_address}, {24'd0, 8'(obs_pc + DEPTH)});
    end
    stream(6, 1'b1);

    // Redirect with a full buffer (after a stall).
    for (int s = 0; s < 3; s++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    redirect_to(1'b1, 8'h40);
    stream(5, 1'b1);

    // Halt mid-stream: drain, then resume at the next sequential PC.
    for (int s = 0; s < 5; s++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("halt_drain", {31'd0, obs_valid}, 32'd0);
    check("halt_pc", {24'd0, bus.imem_address}, {24'd0, next_exp_pc()});
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("halt_resume", {31'd0, obs_valid}, 32'd1);
    stream(4, 1'b1);

    // Redirect while halted: flush and load, fetch starts when halt falls.
    cycle(1'b1, 1'b1, 1'b1, 8'h80);
    for (int s = 0; s < 3; s++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("hredir_valid", {31'd0, obs_valid}, 32'd0);
    check("hredir_addr", {24'd0, bus.imem_address}, 32'h80);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("hredir_resume", {31'd0, obs_valid}, 32'd1);
    check("hredir_pc", {24'd0, obs_pc}, 32'h80);
    stream(4, 1'b1);

    // Asynchronous reset between edges mid-stream.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("arst_addr", {24'd0, bus.imem_address}, {24'd0, RESET_PC});
    check("arst_instr", {8'd0, bus.instr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold_prev = 1'b0;
    restart(RESET_PC);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("arst_lat2", {31'd0, obs_valid}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("arst_lat3", {31'd0, obs_valid}, 32'd1);
    check("arst_pc", {24'd0, obs_pc}, {24'd0, RESET_PC});
    stream(5, 1'b1);

    // Randomized ready / halt / redirect traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0),
            8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
